// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the receiver that will follow:
// parity modes, state encoding and the baud divisor helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_START  = START,
    S_DATA   = DATA,
    S_PARITY = PARITY,
    S_STOP   = STOP
  } uart_state_e;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake and line signals of the parametrised UART transmitter.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_valid;
  logic [DATA_BITS-1:0] i_data;
  logic                 o_ready;
  logic                 o_busy;
  logic                 o_done;
  logic                 serial_out;

  modport master (
    output i_valid, i_data,
    input  o_ready, o_busy, o_done, serial_out
  );

  modport slave (
    input  i_valid, i_data,
    output o_ready, o_busy, o_done, serial_out
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Divide-by-DIV bit-period counter with synchronous restart; tick is high on count DIV-1.
module uart_baud_tick #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (restart || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word in, LSB-first frame out on a registered line.
module uart_tx_param #(
  parameter int CLK_FREQ  = 48000000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_tx_if.slave tx
);
  import uart_pkg::*;

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  uart_state_e          state_q, state_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic                 line_q, ready_q, busy_q, done_q;
  logic                 line_d, accept, load, shift, tick;

  assign accept = tx.i_valid && ready_q;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (accept),
    .tick    (tick)
  );

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    line_d  = 1'b1;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          bcnt_d  = '0;
          load    = 1'b1;
        end
      end
      S_START: begin
        line_d = 1'b0;
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        line_d = shreg_q[0];
        if (tick) begin
          shift = 1'b1;
          if (bcnt_q == LAST_DATA) begin
            bcnt_d  = '0;
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        line_d = par_q;
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) begin
          if (bcnt_q == LAST_STOP) begin
            bcnt_d  = '0;
            state_d = S_IDLE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line, ready, busy and done all come straight from flops so the pin never glitches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      line_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      line_q  <= line_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_q == S_STOP) && (state_d == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      shreg_q <= tx.i_data;
      par_q   <= (PARITY == PAR_ODD) ? ~^tx.i_data : ^tx.i_data;
    end else if (shift) begin
      shreg_q <= {1'b0, shreg_q[DATA_BITS-1:1]};
    end
  end

  assign tx.serial_out = line_q;
  assign tx.o_ready    = ready_q;
  assign tx.o_busy     = busy_q;
  assign tx.o_done     = done_q;

endmodule
